// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU command issuer: command word layout,
// field widths/offsets and the issuer FSM state type.
package tpu_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned ADDR_W   = 8;

  // Command word fields, listed from LSB upwards.
  typedef enum logic [2:0] {
    FLD_SUBMAT_COL = 3'd0,
    FLD_SUBMAT_ROW = 3'd1,
    FLD_ADDR_1     = 3'd2,
    FLD_DIM_3      = 3'd3,
    FLD_DIM_2      = 3'd4,
    FLD_DIM_1      = 3'd5,
    FLD_OPCODE     = 3'd6
  } cmd_field_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } issuer_state_e;

  function automatic int unsigned dim_width(input int unsigned wh);
    return (wh > 1) ? $clog2(wh) : 1;
  endfunction

  function automatic int unsigned submat_width(input int unsigned wh, input int unsigned mm);
    return ((mm / wh) > 1) ? $clog2(mm / wh) : 1;
  endfunction

  function automatic int unsigned cmd_width(input int unsigned dw, input int unsigned sw);
    return OPCODE_W + 3 * dw + ADDR_W + 2 * sw;
  endfunction

  function automatic int unsigned field_width(input cmd_field_e f, input int unsigned dw,
                                              input int unsigned sw);
    case (f)
      FLD_SUBMAT_COL, FLD_SUBMAT_ROW:  return sw;
      FLD_ADDR_1:                      return ADDR_W;
      FLD_DIM_3, FLD_DIM_2, FLD_DIM_1: return dw;
      default:                         return OPCODE_W;
    endcase
  endfunction

  function automatic int unsigned field_offset(input cmd_field_e f, input int unsigned dw,
                                               input int unsigned sw);
    case (f)
      FLD_SUBMAT_COL: return 0;
      FLD_SUBMAT_ROW: return sw;
      FLD_ADDR_1:     return 2 * sw;
      FLD_DIM_3:      return 2 * sw + ADDR_W;
      FLD_DIM_2:      return 2 * sw + ADDR_W + dw;
      FLD_DIM_1:      return 2 * sw + ADDR_W + 2 * dw;
      default:        return 2 * sw + ADDR_W + 3 * dw;
    endcase
  endfunction

  // Command word width at the default geometry (16x16 array, 128 max edge): 29.
  localparam int unsigned CMD_W = cmd_width(dim_width(16), submat_width(16, 128));

endpackage

// File: rtl/tpu_cmd_fifo.sv
// Command queue: power-of-two depth FIFO with registered occupancy.
// full/empty come from the occupancy register only, so they never depend
// combinationally on push/pop.
module tpu_cmd_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are only observed while occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tpu_cmd_issuer.sv
// TPU command issuer: queues host commands, launches them one at a time
// with a single-cycle start pulse, waits for done under a watchdog and
// counts completions.
module tpu_cmd_issuer
  import tpu_pkg::*;
#(
  parameter  int unsigned WIDTH_HEIGHT = 16,
  parameter  int unsigned MAX_MAT_WH   = 128,
  parameter  int unsigned FIFO_DEPTH   = 4,
  parameter  int unsigned TIMEOUT      = 1024,
  localparam int unsigned DIM_W        = dim_width(WIDTH_HEIGHT),
  localparam int unsigned SUB_W        = submat_width(WIDTH_HEIGHT, MAX_MAT_WH),
  localparam int unsigned CMD_WIDTH    = cmd_width(DIM_W, SUB_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 start,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [DIM_W-1:0]     dim_1,
  output logic [DIM_W-1:0]     dim_2,
  output logic [DIM_W-1:0]     dim_3,
  output logic [ADDR_W-1:0]    addr_1,
  output logic [SUB_W-1:0]     accum_table_submat_row_in,
  output logic [SUB_W-1:0]     accum_table_submat_col_in,
  input  logic                 done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [7:0]           cmd_done_count
);

  localparam int unsigned WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned OFF_OP   = field_offset(FLD_OPCODE, DIM_W, SUB_W);
  localparam int unsigned OFF_D1   = field_offset(FLD_DIM_1, DIM_W, SUB_W);
  localparam int unsigned OFF_D2   = field_offset(FLD_DIM_2, DIM_W, SUB_W);
  localparam int unsigned OFF_D3   = field_offset(FLD_DIM_3, DIM_W, SUB_W);
  localparam int unsigned OFF_ADDR = field_offset(FLD_ADDR_1, DIM_W, SUB_W);
  localparam int unsigned OFF_ROW  = field_offset(FLD_SUBMAT_ROW, DIM_W, SUB_W);
  localparam int unsigned OFF_COL  = field_offset(FLD_SUBMAT_COL, DIM_W, SUB_W);

  issuer_state_e        state_q, state_d;
  logic                 start_q, start_d;
  logic [CMD_WIDTH-1:0] fields_q, fields_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [7:0]           count_q, count_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CMD_WIDTH-1:0] fifo_rdata;

  tpu_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (cmd_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready                 = !fifo_full;
  assign busy                      = (state_q != ST_IDLE) || !fifo_empty;
  assign start                     = start_q;
  assign timeout_err               = err_q;
  assign cmd_done_count            = count_q;
  assign opcode                    = fields_q[OFF_OP +: OPCODE_W];
  assign dim_1                     = fields_q[OFF_D1 +: DIM_W];
  assign dim_2                     = fields_q[OFF_D2 +: DIM_W];
  assign dim_3                     = fields_q[OFF_D3 +: DIM_W];
  assign addr_1                    = fields_q[OFF_ADDR +: ADDR_W];
  assign accum_table_submat_row_in = fields_q[OFF_ROW +: SUB_W];
  assign accum_table_submat_col_in = fields_q[OFF_COL +: SUB_W];

  // Issue sequencing: pop and latch in IDLE, pulse start in ISSUE, then
  // wait for done or watchdog expiry. done wins over a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    fields_d = fields_q;
    wd_d     = wd_q;
    count_d  = count_q;
    err_set  = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          fields_d = fifo_rdata;
          start_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          count_d = count_q + 8'd1;
          state_d = ST_IDLE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // All issuer state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      fields_q <= '0;
      wd_q     <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      fields_q <= fields_d;
      wd_q     <= wd_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule
